// File: rtl/sync_frame_pkg.sv
// ============================================================================
// Module      : sync_frame_pkg
// Description : Shared state encoding and sync-word defaults for the frame
//               transmitter and its matching sequence detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int         c_SYNC_LEN     = 5;
    localparam logic [4:0] c_SYNC_PATTERN = 5'b11101;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage : sync_frame_pkg

`default_nettype wire

// File: rtl/piso_shift_reg.sv
// ============================================================================
// Module      : piso_shift_reg
// Description : Parallel-in serial-out shift register, MSB presented first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shift_reg #(
    parameter int WIDTH = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] r_sr;

    // Load has priority over shift so a word accepted in IDLE is never skewed.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sr <= '0;
        end else if (load) begin
            r_sr <= din;
        end else if (shift) begin
            r_sr <= {r_sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = r_sr[WIDTH-1];

endmodule : piso_shift_reg

`default_nettype wire

// File: rtl/sync_frame_tx.sv
// ============================================================================
// Module      : sync_frame_tx
// Description : Serial frame transmitter: sync word, payload (MSB first),
//               then a guard gap of idle bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_frame_tx
    import sync_frame_pkg::*;
#(
    parameter int                  DATA_W       = 8,
    parameter int                  SYNC_LEN     = c_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = c_SYNC_PATTERN,
    parameter int                  GAP_LEN      = 2,
    parameter logic                IDLE_BIT     = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              dataout,
    output logic              frame_active,
    output logic              frame_done
);

    localparam int c_SR_W  = SYNC_LEN + DATA_W;
    localparam int c_CNT_W = $clog2(max3(SYNC_LEN, DATA_W, GAP_LEN)) + 1;

    localparam logic [c_CNT_W-1:0] c_SYNC_LAST = c_CNT_W'(SYNC_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_LEN - 1);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_load_ready;
    logic               r_frame_active;
    logic               r_frame_done;

    logic               w_load;
    logic               w_shift;
    logic               w_msb;

    assign w_load  = (r_state == ST_IDLE) && load_valid;
    assign w_shift = (r_state == ST_SYNC) || (r_state == ST_DATA);

    piso_shift_reg #(
        .WIDTH (c_SR_W)
    ) u_piso (
        .clock (clock),
        .reset (reset),
        .load  (w_load),
        .shift (w_shift),
        .din   ({SYNC_PATTERN, load_data}),
        .msb   (w_msb)
    );

    // Status outputs are registered alongside the state so they always agree
    // with it; the counter restarts at zero on every phase change.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_load_ready   <= 1'b1;
            r_frame_active <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load_valid) begin
                        r_state        <= ST_SYNC;
                        r_cnt          <= '0;
                        r_load_ready   <= 1'b0;
                        r_frame_active <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (r_cnt == c_SYNC_LAST) begin
                        r_state <= ST_DATA;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == c_DATA_LAST) begin
                        r_state        <= ST_GAP;
                        r_cnt          <= '0;
                        r_frame_active <= 1'b0;
                        r_frame_done   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_state      <= ST_IDLE;
                        r_cnt        <= '0;
                        r_load_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_cnt          <= '0;
                    r_load_ready   <= 1'b1;
                    r_frame_active <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready   = r_load_ready;
    assign frame_active = r_frame_active;
    assign frame_done   = r_frame_done;
    assign dataout      = r_frame_active ? w_msb : IDLE_BIT;

endmodule : sync_frame_tx

`default_nettype wire

// File: doc/sync_frame_tx.md
Name: sync_frame_tx

Overview:
Serial frame transmitter and the transmit-side counterpart of the team's 11101 sequence detector. It accepts a parallel payload word through a valid/ready handshake. It then emits a frame on a single-bit line: the sync pattern 11101 (MSB first), the payload (MSB first), then a guard gap of idle bits. The output feeds the detector on the receive side, directly or through the link.

Parameters:
DATA_W, 8, payload width in bits; at least 1.
SYNC_LEN, 5, sync pattern length in bits.
SYNC_PATTERN, 5'b11101, sync word, sent MSB first.
GAP_LEN, 2, number of idle-bit cycles after the payload; at least 1.
IDLE_BIT, 1'b0, line value in IDLE and GAP.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high.
load_valid  input  1  source has a payload word.
load_data  input  DATA_W  payload word; sampled on acceptance only.
load_ready  output  1  block can accept a word (high only in IDLE).
dataout  output  1  serial line.
frame_active  output  1  high while sync or payload bits are on the line.
frame_done  output  1  one-cycle pulse after the last payload bit.

Behaviour:
- Clocking and reset: clock is clock; reset is reset, synchronous, active-high.
- Reset values: state IDLE, counters 0, shift register 0, dataout = IDLE_BIT, frame_active 0, frame_done 0, load_ready 1 (first cycle after reset).
- FSM states:
  - IDLE: load_ready = 1.
  - SYNC: runs SYNC_LEN cycles.
  - DATA: runs DATA_W cycles.
  - GAP: runs GAP_LEN cycles, then returns to IDLE.
- Acceptance:
  - Occurs at a rising edge where load_valid and load_ready are both 1 (state IDLE).
  - The {SYNC_PATTERN, load_data} shift register (SYNC_LEN+DATA_W bits) is loaded and the state goes to SYNC.
- Timing: with acceptance at edge T0, dataout carries frame bit k (k = 0 is the sync MSB) in cycle T0+1+k.
  - SYNC occupies cycles 1..SYNC_LEN.
  - DATA occupies cycles SYNC_LEN+1..SYNC_LEN+DATA_W.
  - GAP follows; IDLE is reached at cycle SYNC_LEN+DATA_W+GAP_LEN+1.
- Back-to-back period: SYNC_LEN+DATA_W+GAP_LEN+1 cycles.
- Shifting: the shift register shifts left once per cycle in SYNC and DATA.
- Moore outputs: dataout, frame_active, load_ready and frame_done depend on registered state only, with no combinational path from inputs.
  - dataout = shift register MSB in SYNC/DATA, otherwise IDLE_BIT.
  - frame_active = (state is SYNC or DATA).
- frame_done:
  - High exactly in the first GAP cycle.
  - Never asserted for an aborted frame.
- Bit counter: width is clog2(max(SYNC_LEN, DATA_W, GAP_LEN)) + 1. It clears on every state change; no wrap inside a phase.
- load_valid while busy: ignored, and load_data is not sampled. The source holds valid until accepted; dropping valid before acceptance is legal.
- Reset mid-frame: the frame is aborted. The next cycle is IDLE with dataout = IDLE_BIT and no frame_done; the partial frame is not resumed.
- Simultaneous reset and load_valid: reset wins, and the word is not accepted.
- The block does not escape payload bits that contain the sync pattern; framing above this block owns that.

Decomposition:
- Package sync_frame_pkg:
  - State enum/localparams ST_IDLE, ST_SYNC, ST_DATA, ST_GAP (2-bit).
  - Default SYNC_PATTERN 5'b11101 and SYNC_LEN 5, shared with the detector.
- Sub-module piso_shift_reg (parallel-in serial-out):
  - Parameter WIDTH; ports load, shift, din[WIDTH-1:0], msb.
  - The FSM, counter and outputs stay in sync_frame_tx.

Test Plan:
1. Reset, then load 8'hA5 with defaults.
   - dataout in cycles 1..13 is 1,1,1,0,1,1,0,1,0,0,1,0,1, then 0,0.
   - frame_done pulses in cycle 14; load_ready returns high in cycle 16.
2. load_valid held high, words 8'h00 then 8'hFF.
   - Second acceptance occurs exactly 16 cycles after the first.
   - The detector on dataout fires exactly once per frame.
3. Pulse load_valid with 8'h3C in cycle 7 of an 8'hA5 frame.
   - load_ready stays 0 and the transmitted payload is still A5.
   - No extra frame is sent.
4. Assert reset in cycle 9 (payload bit 3) of an 8'hA5 frame.
   - Next cycle: dataout 0, frame_active 0, load_ready 1, and no frame_done at any point for that frame.
   - A following 8'h5A load transmits correctly.
5. Instance with DATA_W=4, GAP_LEN=1, load 4'h9.
   - dataout is 1,1,1,0,1,1,0,0,1,0 and the period is 11 cycles.
6. Assert reset and load_valid together on an IDLE edge.
   - No acceptance; dataout stays 0 for 20 cycles while load_valid is low.
